// File: rtl/task_dispatcher_if.sv
// task_dispatcher_if: cpu0 request channel plus the start-command/status bundle
// exchanged with the core start controller.
// Ports: req_valid/req_adr/req_ready (cpu0 push), core_state (idle vector in),
//   cpu0_control/start_cpu_num/cpu_start_adr (start command out), pending_cnt,
//   all_done, and issue_count/stall_count when DISPATCH_STATS_EN is defined.
// Modports: master = cpu0 / controller side, slave = dispatcher.
interface task_dispatcher_if #(
  parameter int PC_W  = 13,
  parameter int DEPTH = 4
`ifdef DISPATCH_STATS_EN
  , parameter int CNT_W = 16
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            req_valid;
  logic [PC_W-1:0] req_adr;
  logic            req_ready;
  logic [3:0]      core_state;
  logic            cpu0_control;
  logic [1:0]      start_cpu_num;
  logic [PC_W-1:0] cpu_start_adr;
  logic [CW-1:0]   pending_cnt;
  logic            all_done;
`ifdef DISPATCH_STATS_EN
  logic [CNT_W-1:0] issue_count;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output req_valid, req_adr, core_state,
    input  req_ready, cpu0_control, start_cpu_num, cpu_start_adr,
           pending_cnt, all_done, issue_count, stall_count
  );
  modport slave (
    input  req_valid, req_adr, core_state,
    output req_ready, cpu0_control, start_cpu_num, cpu_start_adr,
           pending_cnt, all_done, issue_count, stall_count
  );
`else
  modport master (
    output req_valid, req_adr, core_state,
    input  req_ready, cpu0_control, start_cpu_num, cpu_start_adr,
           pending_cnt, all_done
  );
  modport slave (
    input  req_valid, req_adr, core_state,
    output req_ready, cpu0_control, start_cpu_num, cpu_start_adr,
           pending_cnt, all_done
  );
`endif
endinterface

// File: rtl/task_dispatcher.sv
// Purpose: queue cpu0 task addresses and start them round-robin on idle cores 1..3.
// Latency: issue strobe one edge after the FIFO holds a request and a core is idle; 1 task / 2 cycles.
// Backpressure: req_ready drops when DEPTH requests are pending; a full FIFO refuses pushes even on a pop.
//
// Ports: clk, rst (synchronous, active-high), bus (task_dispatcher_if.slave) carrying
//   the cpu0 request channel, core_state, the start command and status outputs.
// Optional feature: define DISPATCH_STATS_EN to add saturating issue_count / stall_count.
module task_dispatcher #(
  parameter int PC_W  = 13,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  task_dispatcher_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || CNT_W < 1) begin : g_param_check
    $error("task_dispatcher: DEPTH must be a power of 2 >= 2 and CNT_W >= 1");
  end

  typedef enum logic {IDLE, ISSUE} state_t;
  state_t state, state_nxt;

  logic [PC_W-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   cnt;
  logic [1:0]      last, pick, num_q;
  logic [PC_W-1:0] adr_q;
  logic [2:0]      cand;
  logic            empty, push, issue;

  // cpu0 is never a worker, so its state bit is deliberately ignored.
  logic unused_core0;
  assign unused_core0 = bus.core_state[0];

  assign cand            = bus.core_state[3:1];
  assign empty           = (cnt == '0);
  assign bus.req_ready   = (cnt != FULL);
  assign bus.pending_cnt = cnt;
  assign push            = bus.req_valid && bus.req_ready;
  // Only IDLE may issue: this hides the one-cycle lag before the controller
  // reports the just-started core as busy.
  assign issue           = (state == IDLE) && !empty && (cand != 3'b000);
  assign bus.all_done    = empty && (state == IDLE) && (cand == 3'b111);

  // Round-robin: search from last+1, wrapping 3 -> 1.
  always_comb begin
    pick = 2'd0;
    case (last)
      2'd1: begin
        if (cand[1])      pick = 2'd2;
        else if (cand[2]) pick = 2'd3;
        else if (cand[0]) pick = 2'd1;
      end
      2'd2: begin
        if (cand[2])      pick = 2'd3;
        else if (cand[0]) pick = 2'd1;
        else if (cand[1]) pick = 2'd2;
      end
      default: begin
        if (cand[0])      pick = 2'd1;
        else if (cand[1]) pick = 2'd2;
        else if (cand[2]) pick = 2'd3;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (issue) state_nxt = ISSUE;
      ISSUE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: the start command is visible only during ISSUE.
  always_comb begin
    bus.cpu0_control  = 1'b0;
    bus.start_cpu_num = 2'd0;
    bus.cpu_start_adr = '0;
    if (state == ISSUE) begin
      bus.cpu0_control  = 1'b1;
      bus.start_cpu_num = num_q;
      bus.cpu_start_adr = adr_q;
    end
  end

  // Pointers, occupancy and captured command fields
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      last   <= 2'd3;
      num_q  <= 2'd0;
      adr_q  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (issue) begin
        rd_ptr <= rd_ptr + AW'(1);
        last   <= pick;
        num_q  <= pick;
        adr_q  <= mem[rd_ptr];
      end
      cnt <= cnt + CW'(push) - CW'(issue);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.req_adr;
  end

`ifdef DISPATCH_STATS_EN
  logic [CNT_W-1:0] issue_q, stall_q;
  logic             stall;

  assign stall = (state == IDLE) && !empty && (cand == 3'b000);

  always_ff @(posedge clk) begin
    if (rst) begin
      issue_q <= '0;
      stall_q <= '0;
    end else begin
      if (issue && issue_q != '1) issue_q <= issue_q + CNT_W'(1);
      if (stall && stall_q != '1) stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign bus.issue_count = issue_q;
  assign bus.stall_count = stall_q;
`endif
endmodule

// File: tb/tb_task_dispatcher.sv
// Bench for task_dispatcher: directed scenarios plus a randomized run, all
// compared against a queue-based reference model and a simple core model.
module tb_task_dispatcher;
  localparam int PC_W  = 13;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  task_dispatcher_if #(.PC_W(PC_W), .DEPTH(DEPTH)) bus ();

  task_dispatcher #(.PC_W(PC_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // reference model
  logic [PC_W-1:0] q[$];
  bit              m_ctl;
  int              m_num;
  int              m_adr;
  int              m_last;
  int              m_issue;
  int              m_stall;
  int              cyc;

  // environment: controller/core model
  bit       busy[4];
  bit       forced;
  bit [3:0] cs_force;
  int       done_pct;

  // DUT issue log
  int log_core[$];
  int log_adr[$];
  int log_cyc[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_cs();
    if (forced) bus.core_state = cs_force;
    else        bus.core_state = {~busy[3], ~busy[2], ~busy[1], 1'b0};
  endtask

  // One clock: update model from the sampled inputs, check outputs, then let
  // the environment react at the falling edge.
  task automatic step();
    bit [3:0]        cs_s;
    bit              rv_s;
    logic [PC_W-1:0] ra_s;
    bit              rst_s;
    bit              iss;
    int              pick;
    int              qn;
    int              started;
    @(posedge clk);
    cyc++;
    cs_s  = bus.core_state;
    rv_s  = bus.req_valid;
    ra_s  = bus.req_adr;
    rst_s = rst;
    if (rst_s) begin
      q.delete();
      m_ctl = 0; m_num = 0; m_adr = 0; m_last = 3; m_issue = 0; m_stall = 0;
    end else begin
      qn  = q.size();
      iss = !m_ctl && qn > 0 && cs_s[3:1] != 3'b000;
      if (!m_ctl && qn > 0 && cs_s[3:1] == 3'b000 && m_stall < (1 << CNT_W) - 1) m_stall++;
      pick = 0;
      if (iss) begin
        for (int k = 1; k <= 3; k++) begin
          int c;
          c = (m_last + k - 1) % 3 + 1;
          if (pick == 0 && cs_s[c]) pick = c;
        end
      end
      m_ctl = iss;
      m_num = iss ? pick : 0;
      m_adr = iss ? int'(q.pop_front()) : 0;
      if (iss) begin
        m_last = pick;
        if (m_issue < (1 << CNT_W) - 1) m_issue++;
      end
      if (rv_s && qn < DEPTH) q.push_back(ra_s);
    end
    #1;
    check("cpu0_control", bus.cpu0_control, m_ctl);
    check("start_cpu_num", bus.start_cpu_num, m_num);
    check("cpu_start_adr", bus.cpu_start_adr, m_adr);
    check("pending_cnt", bus.pending_cnt, q.size());
    check("req_ready", bus.req_ready, q.size() != DEPTH);
    check("all_done", bus.all_done,
          q.size() == 0 && !m_ctl && bus.core_state[3:1] == 3'b111);
`ifdef DISPATCH_STATS_EN
    check("issue_count", bus.issue_count, m_issue);
    check("stall_count", bus.stall_count, m_stall);
`endif
    if (bus.cpu0_control) begin
      log_core.push_back(bus.start_cpu_num);
      log_adr.push_back(bus.cpu_start_adr);
      log_cyc.push_back(cyc);
    end
    @(negedge clk);
    // started core turns busy; other busy cores finish at random
    started = bus.cpu0_control ? int'(bus.start_cpu_num) : 0;
    if (started != 0) busy[started] = 1;
    for (int c = 1; c <= 3; c++)
      if (busy[c] && c != started && $urandom_range(99) < done_pct) busy[c] = 0;
    drive_cs();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_adr   = '0;
    forced = 0; cs_force = 4'b0000; done_pct = 100;
    for (int c = 0; c < 4; c++) busy[c] = 0;
    drive_cs();
    step();
    step();
    rst = 1'b0;
    check("rst_ctl", bus.cpu0_control, 0);
    check("rst_ready", bus.req_ready, 1);
    check("rst_pending", bus.pending_cnt, 0);

    // single push, core 1 first choice
    bus.req_valid = 1'b1; bus.req_adr = 13'h100;
    step();
    bus.req_valid = 1'b0;
    step();
    check("t1_ctl", bus.cpu0_control, 1);
    check("t1_num", bus.start_cpu_num, 1);
    check("t1_adr", bus.cpu_start_adr, 32'h100);
    step();
    check("t1_one_cycle", bus.cpu0_control, 0);
    repeat (3) step();

    // four pushes, cores stay busy once started
    do_reset();
    done_pct = 0;
    log_core.delete(); log_adr.delete(); log_cyc.delete();
    for (int i = 1; i <= 4; i++) begin
      bus.req_valid = 1'b1; bus.req_adr = PC_W'(i * 16);
      step();
    end
    bus.req_valid = 1'b0;
    repeat (6) step();
    check("t2_issues", log_core.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < log_core.size()) begin
        check("t2_core", log_core[i], i + 1);
        check("t2_adr", log_adr[i], (i + 1) * 16);
        if (i > 0) check("t2_spacing", log_cyc[i] - log_cyc[i-1], 2);
      end
    end
    check("t2_pending", bus.pending_cnt, 1);
    done_pct = 100;
    repeat (6) step();

    // no idle core: fill, refuse, then release core 2
    forced = 1; cs_force = 4'b0000; drive_cs();
    for (int i = 0; i < 5; i++) begin
      bus.req_valid = 1'b1; bus.req_adr = PC_W'(32'h200 + i);
      step();
      if (i == 3) check("t3_full_ready", bus.req_ready, 0);
    end
    check("t3_full_cnt", bus.pending_cnt, DEPTH);
    cs_force = 4'b0100; drive_cs();
    step();
    check("t3_num", bus.start_cpu_num, 2);
    check("t3_adr", bus.cpu_start_adr, 32'h200);
    check("t3_cnt_refused", bus.pending_cnt, DEPTH - 1);
    check("t3_ready_back", bus.req_ready, 1);
    bus.req_valid = 1'b0;
    forced = 0; drive_cs();
    repeat (12) step();

    // only core 3 idle right after reset
    do_reset();
    forced = 1; cs_force = 4'b1000; drive_cs();
    bus.req_valid = 1'b1; bus.req_adr = 13'h300;
    step();
    bus.req_valid = 1'b0;
    step();
    check("t4_num", bus.start_cpu_num, 3);
    check("t4_adr", bus.cpu_start_adr, 32'h300);

    // reset during ISSUE
    do_reset();
    cs_force = 4'b0000; drive_cs();
    for (int i = 0; i < 2; i++) begin
      bus.req_valid = 1'b1; bus.req_adr = PC_W'(32'h400 + 16 * i);
      step();
    end
    bus.req_valid = 1'b0;
    cs_force = 4'b1110; drive_cs();
    step();
    check("t5_in_issue", bus.cpu0_control, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t5_ctl", bus.cpu0_control, 0);
    check("t5_pending", bus.pending_cnt, 0);
    check("t5_ready", bus.req_ready, 1);
    log_core.delete(); log_adr.delete(); log_cyc.delete();
    repeat (5) step();
    check("t5_no_issue", log_core.size(), 0);

    // stall then a single issue
    cs_force = 4'b0000; drive_cs();
    bus.req_valid = 1'b1; bus.req_adr = 13'h500;
    step();
    bus.req_valid = 1'b0;
    repeat (3) step();
`ifdef DISPATCH_STATS_EN
    check("t6_stall", bus.stall_count, 3);
`endif
    cs_force = 4'b1110; drive_cs();
    step();
    step();
`ifdef DISPATCH_STATS_EN
    check("t6_issue", bus.issue_count, 1);
`endif
    check("t6_all_done", bus.all_done, 1);
    forced = 0;
    for (int c = 0; c < 4; c++) busy[c] = 0;
    drive_cs();

    // randomized traffic with varying core completion rates
    for (int i = 0; i < 3000; i++) begin
      case ((i / 300) % 3)
        0:       done_pct = 5;
        1:       done_pct = 35;
        default: done_pct = 90;
      endcase
      bus.req_valid = ($urandom_range(99) < 60);
      bus.req_adr   = PC_W'($urandom);
      rst = ($urandom_range(299) == 0);
      step();
    end
    rst = 1'b0;
    bus.req_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
